ttl_multiword_adder_seq: RTL
============================

# ttl_multiword_adder_seq

Sequenced multi-precision adder/subtractor. Accepts one slice of two operands per handshake, least-significant slice first, and produces one registered sum slice per accepted slice. Each slice is four WIDTH-bit groups joined by a 4-group carry-lookahead unit, and a carry flip-flop links slices across cycles. It sits beside the ALU/lookahead datapath chips and supplies sequencing and carry storage for operands wider than one slice.

## Interface
- WIDTH, 4: bits per lookahead group; slice width SW = 4*WIDTH.
- WORDS, 4: slices per operation (2..16); total operand width = WORDS*SW.
- DELAY_RISE, 0: rise delay applied to registered outputs.
- DELAY_FALL, 0: fall delay applied to registered outputs.

Ports:
- Clk  input  1  rising-edge clock.
- Clear_bar  input  1  asynchronous, active-low reset.
- Start  input  1  begins an operation when in IDLE.
- Sub  input  1  sampled with Start; 1 = A minus B, 0 = A plus B.
- Abort  input  1  returns to IDLE from any state.
- In_Valid  input  1  A_Slice and B_Slice are valid this cycle.
- A_Slice  input  SW  operand A slice.
- B_Slice  input  SW  operand B slice.
- In_Ready  output  1  slice is accepted when In_Valid and In_Ready are both high.
- Sum_Slice  output  SW  registered result slice.
- Sum_Valid  output  1  one-cycle pulse for each result slice.
- Index  output  4  index of the slice on Sum_Slice (0 = LSB slice).
- Carry_Out  output  1  final carry; high on subtract means no borrow.
- Overflow  output  1  final two's-complement overflow.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse; Carry_Out and Overflow are valid with it.

## Operation
- States and transitions:
  - IDLE -> RUN on Start.
  - RUN -> DONE when slice WORDS-1 is accepted.
  - DONE -> IDLE after one cycle, unconditionally.
  - Abort moves any state to IDLE. Abort has priority over Start and over slice acceptance in the same cycle.
- On Start:
  - latch Sub into sub_r;
  - carry register c_r <= Sub;
  - slice counter cnt <= 0.
- In RUN, In_Ready = 1. It is 0 in IDLE and DONE.
- B_eff = sub_r ? ~B_Slice : B_Slice.
- Per bit: g = A & B_eff, p = A | B_eff.
- Per group: group G/P are formed from bit g/p, using ripple inside the group.
- The lookahead unit takes the 4 group G/P values and c_r, and produces the carries into groups 1..3 plus the slice carry-out c_slice.
- Sum bits = A ^ B_eff ^ (carry into that bit).
- On an accepted slice:
  - Sum_Slice <= sum;
  - Index <= cnt;
  - Sum_Valid <= 1;
  - c_r <= c_slice;
  - cnt <= cnt + 1.
- In_Valid low in RUN is a stall: c_r, cnt and state hold, and Sum_Valid is 0 the next cycle.
- On acceptance of slice WORDS-1:
  - Carry_Out <= c_slice;
  - Overflow <= carry into the MSB ^ c_slice;
  - Done asserts during the following DONE cycle.
- Carry_Out and Overflow hold their values until the next Start, Abort or reset.
- Start while in RUN or DONE is ignored. Sub is not resampled.
- Arithmetic is modulo 2^SW per slice; only the final slice's carry is exported.

## Timing
- Reset (Clear_bar low, asynchronous):
  - state = IDLE;
  - cnt = 0, c_r = 0;
  - Sum_Slice = 0, Index = 0;
  - Sum_Valid, Carry_Out, Overflow, Busy, Done, In_Ready = 0.
- Reset mid-operation discards the operation; the next Start begins afresh.
- Latency: Sum_Slice and Sum_Valid appear on the edge after acceptance, 1 cycle.
- Throughput: one slice per cycle with no bubbles.
- Total cycles from Start to Done, with no stalls: 1 + WORDS. Done is high in cycle WORDS+1 after the Start edge.
- Abort:
  - Sum_Valid, Busy and Done are 0 from the next edge;
  - Carry_Out and Overflow are cleared to 0;
  - a slice presented with Abort is not accepted.
- Busy, In_Ready and Done are decoded from registered state. No combinational path exists from In_Valid to In_Ready.

## Structure
- Shared package/header holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the constant SLICE_GROUPS = 4.
- One sub-module, carry_lookahead_4 (combinational, active-high):
  - inputs: G[3:0], P[3:0], Cin;
  - outputs: C1, C2, C3, Cout, group G, group P.
- Instantiated once per slice datapath. Group-internal ripple and the FSM live in the top module.

## Test plan
- WIDTH=4, WORDS=4, add A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001 -> four Sum_Valid pulses with Sum_Slice=0x0000 and Index 0..3; Done with Carry_Out=1, Overflow=0.
- Subtract A=0x8000_0000_0000_0000, B=1 -> slices 0xFFFF, 0xFFFF, 0xFFFF, 0x7FFF; Carry_Out=1, Overflow=1.
- Add 0x0000_0000_0001_FFFF + 0x0000_0000_0000_0001 with In_Valid low for 3 cycles between slice 0 and slice 1 -> slice 0 = 0x0000, slice 1 = 0x0002; carry held across the stall; Done at cycle 1+4+3.
- Abort asserted together with slice 2 -> no Sum_Valid for slice 2; IDLE next cycle; Carry_Out=0; a new Start proceeds normally.
- Clear_bar pulsed low mid-RUN between edges -> all outputs 0 immediately, without waiting for a clock edge.
- Start re-pulsed while Busy and Sub toggled -> ignored; the result matches the original Sub.

Source files
------------

// File: rtl/ttl_multiword_adder_seq_pkg.sv
// Shared definitions for the sequenced multi-precision adder/subtractor.
// Holds the FSM state encodings and the slice geometry constant.
package ttl_multiword_adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int SLICE_GROUPS = 4;

endpackage

// File: rtl/ttl_multiword_adder_seq_carry_lookahead_4.sv
// 4-group carry-lookahead unit: group carries C1..C3, carry-out and
// the block-level generate/propagate for the whole slice.
module carry_lookahead_4 (
  input  logic [3:0] G,
  input  logic [3:0] P,
  input  logic       Cin,
  output logic       C1,
  output logic       C2,
  output logic       C3,
  output logic       Cout,
  output logic       Gg,
  output logic       Pg
);

  assign C1   = G[0] | (P[0] & Cin);
  assign C2   = G[1] | (P[1] & G[0]) | (P[1] & P[0] & Cin);
  assign C3   = G[2] | (P[2] & G[1]) | (P[2] & P[1] & G[0])
              | (P[2] & P[1] & P[0] & Cin);
  assign Gg   = G[3] | (P[3] & G[2]) | (P[3] & P[2] & G[1])
              | (P[3] & P[2] & P[1] & G[0]);
  assign Pg   = &P;
  assign Cout = Gg | (Pg & Cin);

endmodule

// File: rtl/ttl_multiword_adder_seq.sv
// Sequenced multi-precision adder/subtractor: one SW-bit slice per
// handshake, LSB slice first, with a carry flip-flop linking slices.
module ttl_multiword_adder_seq
  import ttl_multiword_adder_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int WORDS      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                        Clk,
  input  logic                        Clear_bar,
  input  logic                        Start,
  input  logic                        Sub,
  input  logic                        Abort,
  input  logic                        In_Valid,
  input  logic [SLICE_GROUPS*WIDTH-1:0] A_Slice,
  input  logic [SLICE_GROUPS*WIDTH-1:0] B_Slice,
  output logic                        In_Ready,
  output logic [SLICE_GROUPS*WIDTH-1:0] Sum_Slice,
  output logic                        Sum_Valid,
  output logic [3:0]                  Index,
  output logic                        Carry_Out,
  output logic                        Overflow,
  output logic                        Busy,
  output logic                        Done,
  output logic [1:0]                  state_dbg
);

  localparam int         SW   = SLICE_GROUPS * WIDTH;
  localparam logic [3:0] LAST = 4'(WORDS - 1);

  // Output delays are behavioural-only and are modelled as zero here.
  if (DELAY_RISE < 0 || DELAY_FALL < 0 || WORDS < 2 || WORDS > 16) begin : g_bad_param
    $error("ttl_multiword_adder_seq: illegal parameter value");
  end

  state_t              state_q, state_d;
  logic                sub_r, c_r;
  logic [3:0]          cnt;
  logic [SW-1:0]       b_eff, g, p, carry_bit, sum;
  logic [SLICE_GROUPS-1:0] grp_g, grp_p, grp_cin;
  logic                lah_c1, lah_c2, lah_c3, lah_cout, lah_gg, lah_pg;
  logic                c_slice, accept;

  always_comb begin
    b_eff = sub_r ? ~B_Slice : B_Slice;
    g     = A_Slice & b_eff;
    p     = A_Slice | b_eff;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < SLICE_GROUPS; k++) begin
      grp_p[k] = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        grp_g[k] = g[k*WIDTH+i] | (p[k*WIDTH+i] & grp_g[k]);
        grp_p[k] = grp_p[k] & p[k*WIDTH+i];
      end
    end
  end

  carry_lookahead_4 u_lah (
    .G    (grp_g),
    .P    (grp_p),
    .Cin  (c_r),
    .C1   (lah_c1),
    .C2   (lah_c2),
    .C3   (lah_c3),
    .Cout (lah_cout),
    .Gg   (lah_gg),
    .Pg   (lah_pg)
  );

  assign grp_cin = {lah_c3, lah_c2, lah_c1, c_r};

  // Ripple inside each group from the lookahead-supplied group carry-in.
  always_comb begin
    logic c;
    c         = 1'b0;
    carry_bit = '0;
    for (int k = 0; k < SLICE_GROUPS; k++) begin
      c = grp_cin[k];
      for (int i = 0; i < WIDTH; i++) begin
        carry_bit[k*WIDTH+i] = c;
        c = g[k*WIDTH+i] | (p[k*WIDTH+i] & c);
      end
    end
  end

  assign sum     = A_Slice ^ b_eff ^ carry_bit;
  // Block G/P restate the same carry-out; folded in so every term is used.
  assign c_slice = lah_cout | lah_gg | (lah_pg & c_r);
  assign accept  = (state_q == RUN) && In_Valid && !Abort;

  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (Start) state_d = RUN;
        RUN:     if (accept && cnt == LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q   <= IDLE;
      sub_r     <= 1'b0;
      c_r       <= 1'b0;
      cnt       <= '0;
      Sum_Slice <= '0;
      Index     <= '0;
      Sum_Valid <= 1'b0;
      Carry_Out <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      Sum_Valid <= 1'b0;
      if (Abort) begin
        Carry_Out <= 1'b0;
        Overflow  <= 1'b0;
      end else if (state_q == IDLE && Start) begin
        sub_r     <= Sub;
        c_r       <= Sub;
        cnt       <= '0;
        Carry_Out <= 1'b0;
        Overflow  <= 1'b0;
      end else if (accept) begin
        Sum_Slice <= sum;
        Index     <= cnt;
        Sum_Valid <= 1'b1;
        c_r       <= c_slice;
        cnt       <= cnt + 4'd1;
        if (cnt == LAST) begin
          Carry_Out <= c_slice;
          Overflow  <= carry_bit[SW-1] ^ c_slice;
        end
      end
    end
  end

  assign Busy      = (state_q == RUN);
  assign In_Ready  = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule
